hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_i  input  1  synchronous, active-high reset.
REQ-003 id_rs_i, id_rt_i  input  5 each  source register numbers of the instruction in ID.
REQ-004 id_rd_i  input  5  destination register of the instruction in ID.
REQ-005 id_regwrite_i, id_memread_i  input  1 each  ID instruction writes the register file / is a load.
REQ-006 flush_i  input  1  squash the ID instruction (taken branch/jump).
REQ-007 mem_stall_i  input  1  data-cache miss stall; freeze whole pipeline.
REQ-008 stall_o  output  1  load-use stall; hold PC and IF/ID, insert bubble into EX.
REQ-009 forward_a_o, forward_b_o  output  2 each  registered mux selects for rs/rt in EX: 00 register file, 10 EX/MEM value, 01 MEM/WB value; 11 never driven.
REQ-010 stall_cnt_o  output  16  load-use stall cycle count (see Configuration).

Function
REQ-011 Unit SHALL keep shadow slots EX, MEM, WB, each holding {rd[4:0], regwrite, memread}, advanced each cycle ID->EX->MEM->WB unless mem_stall_i=1.
REQ-012 A slot SHALL be treated as writing only if regwrite=1 and rd!=0; register 0 is never forwarded and never causes a stall.
REQ-013 Load-use hazard SHALL be EX.memread=1 and EX writing and EX.rd equal to id_rs_i or id_rt_i; stall_o SHALL be combinational from current state and inputs and SHALL assert in that cycle.
REQ-014 On advance with stall_o=1 or flush_i=1, EX slot SHALL load a bubble (regwrite=0, memread=0, rd=0) and forward_a_o/forward_b_o SHALL load 00.
REQ-015 On normal advance, forward_a_o SHALL load 10 if EX slot writing and EX.rd==id_rs_i, else 01 if MEM slot writing and MEM.rd==id_rs_i, else 00; forward_b_o identically with id_rt_i.
REQ-016 EX/MEM match SHALL take priority over MEM/WB match when both match (newest value wins).
REQ-017 Forward selects SHALL be valid during the EX cycle of the instruction they were computed for (latency 1 from ID).
REQ-018 mem_stall_i=1 SHALL hold all slots and forward_*_o unchanged and SHALL force stall_o=0 (pipeline already frozen); load-use re-evaluates when mem_stall_i drops.
REQ-019 flush_i=1 SHALL force stall_o=0; flush takes priority over load-use stall; mem_stall_i takes priority over both.
REQ-020 A stalled ID instruction SHALL be re-evaluated next cycle; after one bubble it SHALL see the load in MEM and receive select 01.
REQ-021 Register-file write/read in the same cycle (WB vs ID) is bypassed inside the register file and is out of scope.

Reset
REQ-022 When rst_i=1 at a rising edge, all slots SHALL become bubbles, forward_a_o=forward_b_o=00, stall_cnt_o=0.
REQ-023 rst_i SHALL dominate mem_stall_i, flush_i and any in-progress stall; stall_o SHALL read 0 in the cycle after reset.

Configuration
REQ-024 With macro HAZARD_STALL_COUNT_EN defined, stall_cnt_o SHALL increment by 1 on each rising edge where stall_o=1 and mem_stall_i=0, saturating at 16'hFFFF.
REQ-025 Without HAZARD_STALL_COUNT_EN, no counter SHALL be built and stall_cnt_o SHALL be tied to 16'h0000; all other behaviour identical.

Verification
REQ-026 lw r5 then add r6,r5,r7 back-to-back -> stall_o=1 one cycle, bubble in EX, then forward_a_o=01 in add's EX cycle; counter = 1 if enabled.
REQ-027 add r3,r1,r2; sub r4,r3,r3 -> forward_a_o=forward_b_o=10 in sub's EX cycle, stall_o=0.
REQ-028 add r3..; add r3..; or r8,r3,r0 -> forward_a_o=10 (newest wins), forward_b_o=00 (r0 never forwarded).
REQ-029 lw r5 followed by use with mem_stall_i=1 for 3 cycles -> slots and selects frozen, stall_o=0 during miss, stall_o=1 in first cycle after mem_stall_i drops.
REQ-030 Load-use condition with flush_i=1 same cycle -> stall_o=0, EX slot bubble, selects 00; rst_i=1 mid-stall -> all outputs 00/0 next cycle.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Tracks the destination registers of the instructions in EX, MEM and WB
// and produces the load-use stall request and the registered EX operand
// forwarding selects (00 register file, 10 EX/MEM, 01 MEM/WB).
// Optional build macro HAZARD_STALL_COUNT_EN adds a saturating 16-bit
// load-use stall cycle counter. Without it, stall_cnt_o is tied to zero.
module hazard_forward_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  output logic        stall_o,
  output logic [1:0]  forward_a_o,
  output logic [1:0]  forward_b_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  localparam int unsigned EX  = 0;
  localparam int unsigned MEM = 1;
  localparam int unsigned WB  = 2;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  slot_t      pipe_q [3];
  logic       ex_writing;
  logic       mem_writing;
  logic       load_use;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  // Hazard detection and next forward selects from current slots and ID operands
  always_comb begin
    ex_writing  = pipe_q[EX].regwrite  && (pipe_q[EX].rd  != 5'd0);
    mem_writing = pipe_q[MEM].regwrite && (pipe_q[MEM].rd != 5'd0);
    load_use    = pipe_q[EX].memread && ex_writing &&
                  ((pipe_q[EX].rd == id_rs_i) || (pipe_q[EX].rd == id_rt_i));
    // A frozen pipeline cannot stall further; a squashed instruction has no hazard
    stall_o     = load_use && !flush_i && !mem_stall_i;

    fwd_a_d = FWD_RF;
    if (ex_writing && (pipe_q[EX].rd == id_rs_i))
      fwd_a_d = FWD_EXMEM;
    else if (mem_writing && (pipe_q[MEM].rd == id_rs_i))
      fwd_a_d = FWD_MEMWB;

    fwd_b_d = FWD_RF;
    if (ex_writing && (pipe_q[EX].rd == id_rt_i))
      fwd_b_d = FWD_EXMEM;
    else if (mem_writing && (pipe_q[MEM].rd == id_rt_i))
      fwd_b_d = FWD_MEMWB;
  end

  // Shadow slot advance and forward select registers; miss stall freezes everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 3; i++)
        pipe_q[i] <= BUBBLE;
      forward_a_o <= FWD_RF;
      forward_b_o <= FWD_RF;
    end else if (!mem_stall_i) begin
      pipe_q[WB]  <= pipe_q[MEM];
      pipe_q[MEM] <= pipe_q[EX];
      if (stall_o || flush_i) begin
        pipe_q[EX]  <= BUBBLE;
        forward_a_o <= FWD_RF;
        forward_b_o <= FWD_RF;
      end else begin
        pipe_q[EX]  <= '{rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
        forward_a_o <= fwd_a_d;
        forward_b_o <= fwd_b_d;
      end
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (stall_o && !mem_stall_i && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd;
  logic        rw, mr, fl, ms;
  logic        stall;
  logic [1:0]  fa, fb;
  logic [15:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef HAZARD_STALL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_rs_i      (rs),
    .id_rt_i      (rt),
    .id_rd_i      (rd),
    .id_regwrite_i(rw),
    .id_memread_i (mr),
    .flush_i      (fl),
    .mem_stall_i  (ms),
    .stall_o      (stall),
    .forward_a_o  (fa),
    .forward_b_o  (fb),
    .stall_cnt_o  (cnt)
  );

  // Inputs for one ID cycle, expected combinational stall in that cycle,
  // expected selects/counter after the edge (counter as if enabled).
  typedef struct {
    logic        rst;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, fl, ms;
    logic        e_stall;
    logic [1:0]  e_fa, e_fb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic r, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                              logic w, logic m, logic f, logic x,
                              logic es, logic [1:0] ea, logic [1:0] eb, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.rs = s; v.rt = t; v.rd = d; v.rw = w; v.mr = m; v.fl = f; v.ms = x;
    v.e_stall = es; v.e_fa = ea; v.e_fb = eb; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    rst = v.rst; rs = v.rs; rt = v.rt; rd = v.rd;
    rw = v.rw; mr = v.mr; fl = v.fl; ms = v.ms;
    #3;
    chk({tag, " stall"}, {15'd0, stall}, {15'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, " fwd_a"}, {14'd0, fa}, {14'd0, v.e_fa});
    chk({tag, " fwd_b"}, {14'd0, fb}, {14'd0, v.e_fb});
    chk({tag, " cnt"}, cnt, CNT_EN ? v.e_cnt : 16'd0);
  endtask

  initial begin
    //          rst rs  rt  rd  rw mr fl ms  stall fa     fb     cnt
    // load-use: lw r5 ; add r6,r5,r7
    tbl[0]  = mk(0, 1,  0,  5,  1, 1, 0, 0,  0, 2'b00, 2'b00, 0);
    tbl[1]  = mk(0, 5,  7,  6,  1, 0, 0, 0,  1, 2'b00, 2'b00, 1);
    tbl[2]  = mk(0, 5,  7,  6,  1, 0, 0, 0,  0, 2'b01, 2'b00, 1);
    // add r3,r1,r2 ; sub r4,r3,r3
    tbl[3]  = mk(0, 1,  2,  3,  1, 0, 0, 0,  0, 2'b00, 2'b00, 1);
    tbl[4]  = mk(0, 3,  3,  4,  1, 0, 0, 0,  0, 2'b10, 2'b10, 1);
    // add r3 ; add r3 ; or r8,r3,r0 (newest wins)
    tbl[5]  = mk(0, 1,  2,  3,  1, 0, 0, 0,  0, 2'b00, 2'b00, 1);
    tbl[6]  = mk(0, 4,  9,  3,  1, 0, 0, 0,  0, 2'b01, 2'b00, 1);
    tbl[7]  = mk(0, 3,  0,  8,  1, 0, 0, 0,  0, 2'b10, 2'b00, 1);
    // load into r0 never stalls or forwards
    tbl[8]  = mk(0, 1,  2,  0,  1, 1, 0, 0,  0, 2'b00, 2'b00, 1);
    tbl[9]  = mk(0, 0,  8,  9,  1, 0, 0, 0,  0, 2'b00, 2'b01, 1);
    // lw r5 then use under a three-cycle miss
    tbl[10] = mk(0, 9,  0,  5,  1, 1, 0, 0,  0, 2'b10, 2'b00, 1);
    tbl[11] = mk(0, 7,  5,  6,  1, 0, 0, 1,  0, 2'b10, 2'b00, 1);
    tbl[12] = mk(0, 7,  5,  6,  1, 0, 0, 1,  0, 2'b10, 2'b00, 1);
    tbl[13] = mk(0, 7,  5,  6,  1, 0, 0, 1,  0, 2'b10, 2'b00, 1);
    tbl[14] = mk(0, 7,  5,  6,  1, 0, 0, 0,  1, 2'b00, 2'b00, 2);
    tbl[15] = mk(0, 7,  5,  6,  1, 0, 0, 0,  0, 2'b00, 2'b01, 2);
    // flush beats load-use
    tbl[16] = mk(0, 6,  0,  5,  1, 1, 0, 0,  0, 2'b10, 2'b00, 2);
    tbl[17] = mk(0, 5,  6,  7,  1, 0, 1, 0,  0, 2'b00, 2'b00, 2);
    tbl[18] = mk(0, 9,  5,  1,  1, 0, 0, 0,  0, 2'b00, 2'b01, 2);
    // reset during a load-use hazard with a miss active
    tbl[19] = mk(0, 1,  0,  5,  1, 1, 0, 0,  0, 2'b10, 2'b00, 2);
    tbl[20] = mk(1, 5,  5,  2,  1, 0, 0, 1,  0, 2'b00, 2'b00, 0);
    tbl[21] = mk(0, 5,  5,  2,  1, 0, 0, 0,  0, 2'b00, 2'b00, 0);

    // Reset state
    rst = 1'b1; rs = '0; rt = '0; rd = '0; rw = 1'b0; mr = 1'b0; fl = 1'b0; ms = 1'b1;
    @(posedge clk);
    #1;
    ms = 1'b0;
    #1;
    chk("reset stall", {15'd0, stall}, 16'd0);
    chk("reset fwd_a", {14'd0, fa}, 16'd0);
    chk("reset fwd_b", {14'd0, fb}, 16'd0);
    chk("reset cnt", cnt, 16'd0);

    for (int i = 0; i < 22; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Hand sequence: back-to-back load-use on rt with a second load behind it
    run_vec("seq lw r10",   mk(0, 0, 0, 10, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    run_vec("seq lw r11",   mk(0, 3, 10, 11, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
    run_vec("seq lw r11 b", mk(0, 3, 10, 11, 1, 1, 0, 0, 0, 2'b00, 2'b01, 1));
    run_vec("seq use r11",  mk(0, 11, 10, 12, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2));
    run_vec("seq use r11 b",mk(0, 11, 10, 12, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
